// File: rtl/mask_stream_pkg.sv
// Shared types and the mask builder used by the stream pipe and the register block.
// Mask widths up to MASK_MAX_W are supported; callers truncate to their own width.
package mask_stream_pkg;

    typedef enum logic [1:0] {
        CLR_LSB  = 2'b00,
        KEEP_LSB = 2'b01,
        CLR_MSB  = 2'b10,
        PASS     = 2'b11
    } mask_mode_e;

    localparam int unsigned MASK_MAX_W = 256;

    function automatic logic [MASK_MAX_W-1:0] build_mask(
        input int unsigned n,
        input mask_mode_e  mode,
        input int unsigned dw
    );
        logic [MASK_MAX_W-1:0] ones;
        logic [MASK_MAX_W-1:0] m;
        int unsigned           nn;
        ones = {MASK_MAX_W{1'b1}} >> (MASK_MAX_W - dw);
        nn   = (n > dw) ? dw : n;
        case (mode)
            CLR_LSB:  m = ones & (ones << nn);
            KEEP_LSB: m = ones & ~(ones << nn);
            CLR_MSB:  m = ones >> nn;
            default:  m = ones;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mask_gen.sv
// Combinational (n, mode) -> DATA_W mask; n above DATA_W is clamped to DATA_W.
module mask_gen
    import mask_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_W    = $clog2(DATA_W) + 1
) (
    input  logic [N_W-1:0]    n_i,
    input  mask_mode_e        mode_i,
    output logic [DATA_W-1:0] mask_o
);

    logic [N_W-1:0] nn;

    assign nn     = (n_i > N_W'(DATA_W)) ? N_W'(DATA_W) : n_i;
    assign mask_o = DATA_W'(build_mask(32'(nn), mode_i, DATA_W));

endmodule

// File: rtl/mask_stream_pipe.sv
// Two-stage valid/ready masking pipeline with a saturating delivered-beat counter.
// Stage 1 holds the word and its mask; stage 2 holds the masked result.
module mask_stream_pipe
    import mask_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_W    = $clog2(DATA_W) + 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [N_W-1:0]    s_n,
    input  logic [1:0]        s_mode,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  beat_cnt,
    input  logic              cnt_clr
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] mask_p0;

    logic              vld_p1_q, vld_p1_d;
    logic [DATA_W-1:0] data_p1_q, data_p1_d;
    logic [DATA_W-1:0] mask_p1_q, mask_p1_d;
    logic              vld_p2_q, vld_p2_d;
    logic [DATA_W-1:0] data_p2_q, data_p2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic adv_p1, adv_p2;

    mask_gen #(
        .DATA_W (DATA_W),
        .N_W    (N_W)
    ) u_mask_gen (
        .n_i    (s_n),
        .mode_i (mask_mode_e'(s_mode)),
        .mask_o (mask_p0)
    );

    always_comb begin
        vld_p1_d  = vld_p1_q;
        data_p1_d = data_p1_q;
        mask_p1_d = mask_p1_q;
        vld_p2_d  = vld_p2_q;
        data_p2_d = data_p2_q;
        cnt_d     = cnt_q;

        adv_p2 = !vld_p2_q || m_ready;
        adv_p1 = !vld_p1_q || adv_p2;

        // p0 -> p1: capture word and mask on accept
        if (adv_p1) begin
            vld_p1_d = s_valid;
            if (s_valid) begin
                data_p1_d = s_data;
                mask_p1_d = mask_p0;
            end
        end

        // p1 -> p2: apply mask; output holds while stalled
        if (adv_p2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                data_p2_d = data_p1_q & mask_p1_q;
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (vld_p2_q && m_ready) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            cnt_q     <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        data_p1_q <= data_p1_d;
        mask_p1_q <= mask_p1_d;
    end

    assign s_ready  = adv_p1;
    assign m_valid  = vld_p2_q;
    assign m_data   = data_p2_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_mask_stream_pipe.sv
// Scoreboard bench for mask_stream_pipe: the driver queues expected words on accept,
// a negedge monitor pops on every delivery and also checks stall stability and s_ready.
module tb_mask_stream_pipe;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [5:0]  s_n;
    logic [1:0]  s_mode;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [15:0] beat_cnt;
    logic        cnt_clr;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    bit          rand_bp = 0;

    int          acc = 0;
    int          del = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = '0;

    mask_stream_pipe #(
        .DATA_W (32),
        .N_W    (6),
        .CNT_W  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_n      (s_n),
        .s_mode   (s_mode),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .beat_cnt (beat_cnt),
        .cnt_clr  (cnt_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bit-by-bit reference: independent of the shift formulation in the design.
    function automatic logic [31:0] model(input logic [31:0] d, input int n, input int mode);
        logic [31:0] r;
        int nn;
        nn = (n > 32) ? 32 : n;
        for (int i = 0; i < 32; i++) begin
            case (mode)
                0:       r[i] = (i >= nn) ? d[i] : 1'b0;
                1:       r[i] = (i < nn) ? d[i] : 1'b0;
                2:       r[i] = (i < 32 - nn) ? d[i] : 1'b0;
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    task automatic send(input logic [31:0] d, input int n, input int mode, input logic [31:0] exp);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_n     = 6'(n);
        s_mode  = 2'(mode);
        forever begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                exp_q.push_back(exp);
                break;
            end
            guard++;
            if (guard > 1000) begin
                chk("send_timeout", 64'(guard), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || m_valid === 1'b1) && g < 500) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    always @(posedge clk) begin
        #2;
        if (rand_bp) m_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        int inflight;
        if (rst !== 1'b0) begin
            exp_q.delete();
            acc        = 0;
            del        = 0;
            stall_prev = 1'b0;
        end else begin
            inflight = acc - del;
            chk("s_ready_rule", 64'(s_ready), 64'((inflight < 2) || (m_ready === 1'b1)));
            if (stall_prev) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", 64'(m_data), 64'(prev_data));
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(m_data), 64'hDEAD_0000_0000);
                end else begin
                    chk("beat_data", 64'(m_data), 64'(exp_q.pop_front()));
                end
                del++;
            end
            if (s_valid === 1'b1 && s_ready === 1'b1) acc++;
            stall_prev = (m_valid === 1'b1) && (m_ready !== 1'b1);
            prev_data  = m_data;
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h1234_5678;
        s_n     = 6'd0;
        s_mode  = 2'd3;
        m_ready = 1'b1;
        cnt_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("rst_idle_valid", 64'(m_valid), 64'd0);

        send(32'hDEADBEEF, 4, 0, 32'hDEADBEE0);
        chk("lat_edge1_valid", 64'(m_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2_valid", 64'(m_valid), 64'd1);
        chk("lat_edge2_data", 64'(m_data), 64'hDEADBEE0);

        send(32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
        send(32'hFFFFFFFF, 8, 1, 32'h000000FF);
        send(32'hFFFFFFFF, 8, 2, 32'h00FFFFFF);
        send(32'hFFFFFFFF, 8, 3, 32'hFFFFFFFF);
        send(32'hFFFFFFFF, 32, 0, 32'h00000000);
        send(32'hFFFFFFFF, 63, 0, 32'h00000000);
        send(32'hA5A55A5A, 32, 1, 32'hA5A55A5A);
        send(32'hFFFFFFFF, 40, 2, 32'h00000000);
        send(32'h12345678, 63, 3, 32'h12345678);
        drain();
        chk("cnt_after_directed", 64'(beat_cnt), 64'd10);

        rand_bp = 1;
        for (int i = 0; i < 100; i++) begin
            logic [31:0] d;
            int n;
            int mode;
            d    = $urandom;
            n    = $urandom_range(0, 40);
            mode = $urandom_range(0, 3);
            send(d, n, mode, model(d, n, mode));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_bp = 0;
        @(posedge clk);
        #3;
        m_ready = 1'b1;
        drain();
        chk("cnt_after_random", 64'(beat_cnt), 64'd110);

        for (int i = 0; i < 65541; i++) begin
            send(32'(i), 0, 3, 32'(i));
        end
        drain();
        chk("cnt_saturated", 64'(beat_cnt), 64'hFFFF);

        send(32'hCAFE0001, 0, 3, 32'hCAFE0001);
        g = 0;
        while (m_valid !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("clr_wait_valid", 64'(m_valid), 64'd1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", 64'(beat_cnt), 64'd0);
        send(32'hCAFE0002, 0, 3, 32'hCAFE0002);
        drain();
        chk("cnt_after_clr", 64'(beat_cnt), 64'd1);

        m_ready = 1'b0;
        send(32'h00000001, 0, 3, 32'h00000001);
        send(32'h00000002, 0, 3, 32'h00000002);
        chk("full_s_ready_low", 64'(s_ready), 64'd0);
        chk("full_m_valid", 64'(m_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_m_data", 64'(m_data), 64'd0);
        chk("midrst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("midrst_s_ready", 64'(s_ready), 64'd1);
        m_ready = 1'b1;
        send(32'h0F0F0F0F, 4, 1, 32'h0000000F);
        drain();
        chk("cnt_after_midrst", 64'(beat_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
